// File: rtl/icache_responder_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_responder_pkg;

  localparam int ICACHE_SETS   = 16;
  localparam int ICACHE_WORD_W = 32;

  typedef logic [ICACHE_WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Frame layout for the default geometry: {valid, tag, data}.
  typedef struct packed {
    logic                                        valid;
    logic [ICACHE_WORD_W-3-$clog2(ICACHE_SETS):0] tag;
    word_t                                       data;
  } icache_frame_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/icache_responder_frame_array.sv
// Frame storage: per-set valid bit (async reset), tag and data words.
// One combinational read port, one synchronous write port, global invalidate.
module icache_responder_frame_array #(
  parameter  int SETS   = 16,
  parameter  int WORD_W = 32,
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = WORD_W - 2 - IDX_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [WORD_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_invalidate
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [WORD_W-1:0] r_data [SETS];

  // Valid bits: invalidate wins over a same-cycle fill, so the filled frame stays invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_invalidate) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data payload is written on every fill, even when invalidate suppresses valid.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: lookup/miss FSM, fill forwarding and hit/miss counters.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter  int SETS   = ICACHE_SETS,
  parameter  int WORD_W = ICACHE_WORD_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = WORD_W - 2 - IDX_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dpif_imemREN,
  input  logic [WORD_W-1:0] dpif_imemaddr,
  output logic              dpif_ihit,
  output logic [WORD_W-1:0] dpif_imemload,
  input  logic              dpif_invalidate,
  output logic              ccif_iREN,
  output logic [WORD_W-1:0] ccif_iaddr,
  input  logic              ccif_iwait,
  input  logic [WORD_W-1:0] ccif_iload,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  icache_state_t     r_state;
  icache_state_t     w_state_next;
  logic [WORD_W-1:0] r_miss_addr;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;

  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [WORD_W-1:0] w_rd_data;
  logic              w_lookup_hit;
  logic              w_fill;
  logic              w_count_hit;
  logic              w_count_miss;

  // Lookups always index with the live fetch address; fills use the latched miss address.
  icache_responder_frame_array #(
    .SETS   (SETS),
    .WORD_W (WORD_W)
  ) u_frames (
    .i_clk        (CLK),
    .i_rst_n      (nRST),
    .i_rd_idx     (dpif_imemaddr[IDX_W+1:2]),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_data    (w_rd_data),
    .i_wr_en      (w_fill),
    .i_wr_idx     (r_miss_addr[IDX_W+1:2]),
    .i_wr_tag     (r_miss_addr[WORD_W-1:IDX_W+2]),
    .i_wr_data    (ccif_iload),
    .i_invalidate (dpif_invalidate)
  );

  assign w_lookup_hit = dpif_imemREN & w_rd_valid
                      & (w_rd_tag == dpif_imemaddr[WORD_W-1:IDX_W+2]);

  // Next state and all datapath/memory outputs; everything defaults to idle/zero.
  always_comb begin
    w_state_next  = r_state;
    dpif_ihit     = 1'b0;
    dpif_imemload = '0;
    ccif_iREN     = 1'b0;
    ccif_iaddr    = '0;
    w_fill        = 1'b0;
    w_count_hit   = 1'b0;
    w_count_miss  = 1'b0;
    case (r_state)
      IDLE: begin
        if (dpif_imemREN) begin
          if (w_lookup_hit) begin
            dpif_ihit     = 1'b1;
            dpif_imemload = w_rd_data;
            w_count_hit   = 1'b1;
          end else begin
            w_count_miss = 1'b1;
            w_state_next = FETCH;
          end
        end
      end
      FETCH: begin
        ccif_iREN  = 1'b1;
        ccif_iaddr = r_miss_addr;
        if (!ccif_iwait) begin
          w_fill       = 1'b1;
          w_state_next = IDLE;
          // Forward only if the datapath is still asking for the missed word (no branch away).
          if (dpif_imemREN && (dpif_imemaddr == r_miss_addr)) begin
            dpif_ihit     = 1'b1;
            dpif_imemload = ccif_iload;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, miss address and saturating counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_count_miss) begin
        r_miss_addr  <= dpif_imemaddr;
        r_miss_count <= sat_inc(r_miss_count);
      end
      if (w_count_hit) begin
        r_hit_count <= sat_inc(r_hit_count);
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: misses, hits, eviction, branch, invalidate, reset, saturation.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        inval = 1'b0;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_hits = 32'd0;
  logic [31:0] exp_misses = 32'd0;

  icache_responder dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .dpif_imemREN    (ren),
    .dpif_imemaddr   (addr),
    .dpif_ihit       (ihit),
    .dpif_imemload   (imemload),
    .dpif_invalidate (inval),
    .ccif_iREN       (iren),
    .ccif_iaddr      (iaddr),
    .ccif_iwait      (iwait),
    .ccif_iload      (iload),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Miss on address a, hold iwait for nwait cycles, then fill with d and expect forwarding.
  task automatic fetch_miss(input logic [31:0] a, input int nwait, input logic [31:0] d);
    @(negedge CLK); ren = 1'b1; addr = a; iwait = 1'b1; #1;
    chk("miss_lookup_ihit", {31'd0, ihit}, 32'd0);
    chk("miss_lookup_iren", {31'd0, iren}, 32'd0);
    exp_misses = sat(exp_misses);
    for (int i = 0; i < nwait; i++) begin
      @(negedge CLK); #1;
      chk("wait_iren", {31'd0, iren}, 32'd1);
      chk("wait_iaddr", iaddr, a);
      chk("wait_ihit", {31'd0, ihit}, 32'd0);
    end
    @(negedge CLK); iwait = 1'b0; iload = d; #1;
    chk("fill_iren", {31'd0, iren}, 32'd1);
    chk("fill_iaddr", iaddr, a);
    chk("fill_fwd_ihit", {31'd0, ihit}, 32'd1);
    chk("fill_fwd_load", imemload, d);
    @(negedge CLK); ren = 1'b0; iwait = 1'b1; #1;
    chk("after_fill_iren", {31'd0, iren}, 32'd0);
    $display("miss  addr=%h data=%h misses=%0d", a, d, exp_misses);
  endtask

  // Expect a same-cycle hit on address a returning d.
  task automatic hit_chk(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK); ren = 1'b1; addr = a; iwait = 1'b1; #1;
    chk("hit_ihit", {31'd0, ihit}, 32'd1);
    chk("hit_load", imemload, d);
    chk("hit_iren", {31'd0, iren}, 32'd0);
    exp_hits = sat(exp_hits);
    $display("hit   addr=%h data=%h hits=%0d", a, d, exp_hits);
  endtask

  // Idle cycle: no fetch, compare counters and idle outputs.
  task automatic idle_chk();
    @(negedge CLK); ren = 1'b0; inval = 1'b0; #1;
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("idle_ihit", {31'd0, ihit}, 32'd0);
    chk("idle_load", imemload, 32'd0);
    $display("idle  hits=%h misses=%h", hit_count, miss_count);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    chk("rst_iren", {31'd0, iren}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(negedge CLK); nRST = 1'b1;

    // Cold miss then hit
    fetch_miss(32'h0000_0040, 3, 32'h2008_0001);
    hit_chk(32'h0000_0040, 32'h2008_0001);
    idle_chk();

    // Conflict eviction: 0x40 and 0x440 share index 0
    fetch_miss(32'h0000_0440, 0, 32'h1111_0440);
    fetch_miss(32'h0000_0040, 0, 32'h2008_0001);
    idle_chk();

    // Branch mid-fill: miss 0x104, datapath moves to 0x200 while waiting
    @(negedge CLK); ren = 1'b1; addr = 32'h0000_0104; iwait = 1'b1; #1;
    chk("br_lookup_ihit", {31'd0, ihit}, 32'd0);
    exp_misses = sat(exp_misses);
    @(negedge CLK); addr = 32'h0000_0200; #1;
    chk("br_wait_iaddr", iaddr, 32'h0000_0104);
    chk("br_wait_ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK); iwait = 1'b0; iload = 32'hAAAA_0104; #1;
    chk("br_fill_ihit", {31'd0, ihit}, 32'd0);
    chk("br_fill_load", imemload, 32'd0);
    chk("br_fill_iren", {31'd0, iren}, 32'd1);
    @(negedge CLK); iwait = 1'b1; #1;
    chk("br_new_lookup_ihit", {31'd0, ihit}, 32'd0);
    chk("br_new_lookup_iren", {31'd0, iren}, 32'd0);
    exp_misses = sat(exp_misses);
    @(negedge CLK); #1;
    chk("br_new_iren", {31'd0, iren}, 32'd1);
    chk("br_new_iaddr", iaddr, 32'h0000_0200);
    @(negedge CLK); iwait = 1'b0; iload = 32'hBBBB_0200; #1;
    chk("br_new_fill_ihit", {31'd0, ihit}, 32'd1);
    chk("br_new_fill_load", imemload, 32'hBBBB_0200);
    @(negedge CLK); iwait = 1'b1; ren = 1'b0;
    $display("branch miss=0x104 redirected=0x200");
    hit_chk(32'h0000_0104, 32'hAAAA_0104);
    idle_chk();

    // Invalidate: same-cycle lookup uses pre-clear valid bits
    fetch_miss(32'h0000_0040, 1, 32'h2008_0001);
    fetch_miss(32'h0000_0044, 0, 32'h2008_0002);
    hit_chk(32'h0000_0040, 32'h2008_0001);
    hit_chk(32'h0000_0044, 32'h2008_0002);
    @(negedge CLK); ren = 1'b1; addr = 32'h0000_0040; inval = 1'b1; #1;
    chk("inval_same_cycle_ihit", {31'd0, ihit}, 32'd1);
    exp_hits = sat(exp_hits);
    @(negedge CLK); inval = 1'b0; ren = 1'b0;
    $display("invalidate pulse");
    fetch_miss(32'h0000_0040, 0, 32'h2008_0001);

    // Invalidate coincident with fill: forwarded, but frame left invalid
    @(negedge CLK); ren = 1'b1; addr = 32'h0000_0044; iwait = 1'b1; #1;
    chk("invfill_lookup_ihit", {31'd0, ihit}, 32'd0);
    exp_misses = sat(exp_misses);
    @(negedge CLK); iwait = 1'b0; iload = 32'h2008_0002; inval = 1'b1; #1;
    chk("invfill_fwd_ihit", {31'd0, ihit}, 32'd1);
    chk("invfill_fwd_load", imemload, 32'h2008_0002);
    @(negedge CLK); inval = 1'b0; iwait = 1'b1; #1;
    chk("invfill_frame_invalid", {31'd0, ihit}, 32'd0);
    exp_misses = sat(exp_misses);
    @(negedge CLK); iwait = 1'b0; #1;
    chk("invfill_refill_ihit", {31'd0, ihit}, 32'd1);
    @(negedge CLK); ren = 1'b0; iwait = 1'b1;
    $display("invalidate coincident with fill addr=44");
    fetch_miss(32'h0000_0040, 0, 32'h2008_0001);
    hit_chk(32'h0000_0044, 32'h2008_0002);
    idle_chk();

    // Async reset mid-FETCH
    @(negedge CLK); ren = 1'b1; addr = 32'h0000_0080; iwait = 1'b1;
    @(negedge CLK); #1;
    chk("pre_rst_iren", {31'd0, iren}, 32'd1);
    #2; nRST = 1'b0; #1;
    chk("async_rst_iren", {31'd0, iren}, 32'd0);
    chk("async_rst_iaddr", iaddr, 32'd0);
    chk("async_rst_ihit", {31'd0, ihit}, 32'd0);
    chk("async_rst_hits", hit_count, 32'd0);
    chk("async_rst_misses", miss_count, 32'd0);
    exp_hits = 32'd0;
    exp_misses = 32'd0;
    @(negedge CLK); nRST = 1'b1; ren = 1'b0;
    $display("async reset during fetch");
    fetch_miss(32'h0000_0040, 0, 32'h2008_0001);
    idle_chk();

    // Hit counter saturation
    @(negedge CLK); ren = 1'b0;
    force dut.r_hit_count = 32'hFFFF_FFFE;
    #1 release dut.r_hit_count;
    #1 chk("sat_preload", hit_count, 32'hFFFF_FFFE);
    exp_hits = 32'hFFFF_FFFE;
    hit_chk(32'h0000_0040, 32'h2008_0001);
    hit_chk(32'h0000_0040, 32'h2008_0001);
    hit_chk(32'h0000_0040, 32'h2008_0001);
    idle_chk();
    chk("sat_final", hit_count, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache.
- Serves instruction fetches from the datapath. Produces dpif_ihit / dpif_imemload, which the pipeline stall/flush logic consumes.
- On a miss, performs a single-word read request to the memory controller (ccif side) and fills the frame.
- Sits between the fetch stage (PC) and the memory arbiter.

Parameters:
- SETS, 16, number of one-word frames; power of two, ≥ 2.
- WORD_W, 32, data/address width.
- IDX_W, log2(SETS), index bits (derived, not overridable).
- TAG_W, WORD_W-2-IDX_W, tag bits (derived).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- dpif_imemREN  in  1  datapath fetch request.
- dpif_imemaddr  in  WORD_W  fetch byte address (word-aligned).
- dpif_ihit  out  1  fetch satisfied this cycle.
- dpif_imemload  out  WORD_W  instruction word; valid when dpif_ihit=1.
- dpif_invalidate  in  1  clear all valid bits (halt/self-modify).
- ccif_iREN  out  1  memory read request.
- ccif_iaddr  out  WORD_W  memory read address.
- ccif_iwait  in  1  memory busy; data valid when 0 while iREN=1.
- ccif_iload  in  WORD_W  memory read data.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

Behaviour:
- Address split:
  - [1:0] ignored.
  - [IDX_W+1:2] index.
  - [WORD_W-1:IDX_W+2] tag.
- Frame contents: {valid, tag[TAG_W], data[WORD_W]}.
- Reset (async, nRST=0):
  - All valid=0, state=IDLE, miss_addr=0, both counters=0.
  - Outputs: dpif_ihit=0, dpif_imemload=0, ccif_iREN=0, ccif_iaddr=0.
- States: IDLE, FETCH.
- IDLE:
  - Hit = imemREN & valid[idx] & (tag[idx]==addr tag).
  - On hit: dpif_ihit=1 combinationally the same cycle; dpif_imemload=frame data; hit_count+1.
  - On miss (imemREN & !hit): dpif_ihit=0; latch miss_addr=dpif_imemaddr; miss_count+1; next=FETCH.
  - imemREN=0: dpif_ihit=0, no counter change, stay IDLE.
  - dpif_imemload=0 whenever dpif_ihit=0.
- FETCH:
  - ccif_iREN=1, ccif_iaddr=miss_addr; ccif_iaddr=0 when iREN=0.
  - While ccif_iwait=1: hold, dpif_ihit=0.
  - On ccif_iwait=0:
    - Write frame[miss_addr idx] = {1, miss tag, ccif_iload}.
    - Forward: dpif_ihit=1 and dpif_imemload=ccif_iload, only if imemREN=1 and dpif_imemaddr==miss_addr; else dpif_ihit=0.
    - Next=IDLE.
  - Minimum miss latency: 2 cycles (miss cycle, then fill cycle with iwait=0).
- Datapath address change mid-FETCH (branch flush): the fill still completes into miss_addr's frame. No ihit for the new address until the IDLE lookup afterward.
- dpif_invalidate:
  - Synchronous; clears every valid bit at the clock edge.
  - Beats a simultaneous fill: the frame is written but valid stays 0. Forwarding in that cycle still occurs.
  - Same-cycle IDLE lookup uses the pre-clear valid bits.
  - Does not abort FETCH.
- Counters saturate at 32'hFFFF_FFFF; no wrap.
- Only one outstanding memory request; no new lookups while in FETCH.
- Reset mid-FETCH: iREN drops immediately (async). The memory side treats a dropped iREN as cancelled.

Decomposition:
- aww_types_pkg gains:
  - icache_state_t enum {IDLE, FETCH}.
  - icache_frame_t packed struct {valid, tag, data}.
  - ICACHE_SETS constant = 16.
- Word type: word_t from cpu_types_pkg.
- One sub-module: icache_frame_array.
  - Contents: SETS frames, async-reset valid bits, one combinational read port, one synchronous write port, global invalidate.
- FSM, forwarding and counters stay in icache_responder.

Test Plan:
- Cold miss, then hit:
  - Stimulus: after reset, imemREN=1, addr=0x0000_0040; iwait=1 for 3 cycles, then iwait=0 with iload=0x2008_0001.
  - Response:
    - iREN=1, iaddr=0x40 during FETCH.
    - Fill cycle: ihit=1, imemload=0x2008_0001.
    - Next access to 0x40: ihit in 0 extra cycles.
    - miss_count=1, hit_count=1.
- Conflict eviction:
  - Stimulus: fill 0x40, then request 0x80 (same index 0 for SETS=16 is 0x00/0x40; use 0x40 and 0x440).
  - Response:
    - 0x440 misses, replaces the frame.
    - Re-request 0x40 misses again; miss_count=3.
- Branch mid-fill:
  - Stimulus: miss on 0x100; while iwait=1, addr changes to 0x200.
  - Response:
    - Fill cycle ihit=0.
    - Frame idx of 0x100 becomes valid.
    - Next cycle IDLE lookup of 0x200 misses and starts a new FETCH with iaddr=0x200.
- Invalidate:
  - Stimulus: fill 0x40 and 0x44; pulse dpif_invalidate 1 cycle.
  - Response: both subsequent fetches miss. Invalidate coincident with fill leaves the frame invalid but ihit=1 in that cycle.
- Async reset mid-FETCH:
  - Stimulus: assert nRST=0 while iREN=1 with iwait=1.
  - Response: iREN=0 and ihit=0 immediately (no clock edge); counters=0; first fetch after release misses.
- Counter saturation:
  - Stimulus: force hit_count to 32'hFFFF_FFFE, issue 3 hits.
  - Response: hit_count ends at 32'hFFFF_FFFF.
